buffer_multi_channel: RTL

//   Multi-channel successor to the single-slot capture buffer.
//   - NCH independent input channels, each with a one-entry holding slot, an avail flag and a sticky overflow flag.
//   - A round-robin arbiter drains pending slots into one registered output stage with a valid/ready handshake.
//   - Sits between pulse-counter/ADC result producers and the pipe/FIFO writer. Single clock domain.

---
 rtl/buffer_multi_channel.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/buffer_multi_channel.sv
// ---------------------------------------------------------------------------
// buffer_multi_channel
//   Multi-channel capture buffer. Each of NCH input channels owns a one-entry
//   holding slot, an avail flag and a sticky overflow flag. A round-robin
//   arbiter moves pending slots into a single registered output stage that
//   uses a valid/ready handshake. Single clock domain, synchronous
//   active-high reset.
//
// Ports
//   clk             in   1          system clock, all logic on posedge
//   reset           in   1          synchronous active-high reset
//   enable          in   1          global capture enable (0 = set[] ignored)
//   set             in   NCH        per-channel capture strobe
//   data            in   NCH*WIDTH  channel i data = data[i*WIDTH +: WIDTH]
//   clear_overflow  in   1          clears all overflow flags
//   out_ready       in   1          downstream accepts the output word
//   out_valid       out  1          out_data/out_channel hold a valid word
//   out_data        out  WIDTH      drained word
//   out_channel     out  CHW        source channel of out_data
//   avail           out  NCH        slot i holds undrained data
//   overflow        out  NCH        sticky: slot i overwritten before drain
// ---------------------------------------------------------------------------
module buffer_multi_channel #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NCH-1:0]       set,
  input  logic [NCH*WIDTH-1:0] data,
  input  logic                 clear_overflow,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [CHW-1:0]       out_channel,
  output logic [NCH-1:0]       avail,
  output logic [NCH-1:0]       overflow
);

  // Holding slots; contents are only meaningful while the matching avail bit is set.
  logic [WIDTH-1:0] slot_q [NCH];

  logic [NCH-1:0]   avail_q,     avail_d;
  logic [NCH-1:0]   overflow_q,  overflow_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CHW-1:0]   out_ch_q,    out_ch_d;
  logic [CHW-1:0]   ptr_q,       ptr_d;

  logic             load_c;
  logic             found_c;
  logic             grant_c;
  logic [CHW-1:0]   gnt_idx_c;
  logic [NCH-1:0]   gnt_vec_c;
  logic [NCH-1:0]   cap_c;

  // Qualified capture strobes.
  assign cap_c  = set & {NCH{enable}};

  // The output stage may take a new word when empty or when its word is consumed.
  assign load_c = !out_valid_q || out_ready;

  // Round-robin search over the registered avail bits, starting just after ptr_q.
  always_comb begin
    int unsigned    cand;
    logic [CHW-1:0] cand_ch;
    found_c   = 1'b0;
    gnt_idx_c = '0;
    cand      = 0;
    cand_ch   = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      cand_ch = CHW'(cand);
      if (!found_c && avail_q[cand_ch]) begin
        found_c   = 1'b1;
        gnt_idx_c = cand_ch;
      end
    end
  end

  assign grant_c   = load_c && found_c;
  assign gnt_vec_c = grant_c ? (NCH'(1) << gnt_idx_c) : '0;

  // Next-state for flags, output stage and pointer.
  always_comb begin
    avail_d     = cap_c | (avail_q & ~gnt_vec_c);
    // An overwrite is a capture into a slot that still holds an undrained word.
    overflow_d  = (clear_overflow ? '0 : overflow_q) | (cap_c & avail_q & ~gnt_vec_c);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_c) begin
      out_valid_d = found_c;
    end
    if (grant_c) begin
      out_data_d = slot_q[gnt_idx_c];
      out_ch_d   = gnt_idx_c;
      ptr_d      = gnt_idx_c;
    end
  end

  // Control and output registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      avail_q     <= '0;
      overflow_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= CHW'(NCH - 1);
    end else begin
      avail_q     <= avail_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  // Slot storage; a grant reads the old contents in the same cycle a capture writes new ones.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cap_c[i]) begin
        slot_q[i] <= data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_ch_q;
  assign avail       = avail_q;
  assign overflow    = overflow_q;

endmodule
